// File: rtl/coco_mem_bus_unit.sv
// coco_mem_bus_unit: load/store bus interface with posted write buffer,
// load alignment/extension, misalignment detection and bus timeout.
module coco_mem_bus_unit #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int WBUF_DEPTH = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       cpu_req,
    input  logic                       cpu_we,
    input  logic [1:0]                 cpu_size,
    input  logic                       cpu_signed,
    input  logic [AW-1:0]              cpu_addr,
    input  logic [DW-1:0]              cpu_wdata,
    output logic                       cpu_ack,
    output logic [DW-1:0]              cpu_rdata,
    output logic                       cpu_err,
    output logic [1:0]                 cpu_err_code,
    output logic [AW-$clog2(DW/8)-1:0] A,
    output logic [DW/8-1:0]            BE,
    output logic [DW-1:0]              WData,
    input  logic [DW-1:0]              RData,
    output logic                       Req,
    output logic                       RW,
    input  logic                       Ready,
    output logic                       wbuf_empty
);
    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);
    localparam int WW = AW - OW;
    localparam int EW = WW + NB + DW;
    localparam int PW = WBUF_DEPTH > 1 ? $clog2(WBUF_DEPTH) : 1;
    localparam int CW = $clog2(WBUF_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WR_BUS, RD_BUS, GAP} state_t;
    state_t state_q, state_d;

    logic [EW-1:0] mem_q [WBUF_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   tmo_q;
    logic          ack_q, err_q, req_q, rw_q;
    logic [1:0]    code_q;
    logic [DW-1:0] rdata_q, wd_q;
    logic [WW-1:0] a_q;
    logic [NB-1:0] be_q;

    logic [OW-1:0] o, amask;
    logic [NB-1:0] be_w;
    logic [DW-1:0] wd_w, sh, keep;
    logic          mis, full, take, push, pop, abort, ld_go, rd_done, sext;

    always_comb begin
        o = cpu_addr[OW-1:0];
        amask = OW'((1 << cpu_size) - 1);
        mis = (cpu_size == 2'd3 && DW == 32) || (o & amask) != '0;
        be_w = (cpu_size == 2'd0 ? NB'(1) : cpu_size == 2'd1 ? NB'(3) :
                cpu_size == 2'd2 ? NB'(15) : {NB{1'b1}}) << o;
        wd_w = cpu_size == 2'd0 ? {NB{cpu_wdata[7:0]}} :
               cpu_size == 2'd1 ? {(NB/2){cpu_wdata[15:0]}} :
               cpu_size == 2'd2 ? {(NB/4){cpu_wdata[31:0]}} : cpu_wdata;
        // keep masks the access-size bits; its top bit selects the sign bit
        sh = RData >> {o, 3'b000};
        keep = ~({DW{1'b1}} << (8 << cpu_size));
        sext = cpu_signed && |(sh & (keep ^ (keep >> 1)));
        full = cnt_q == CW'(WBUF_DEPTH);
        abort = TIMEOUT != 0 && req_q && !Ready && tmo_q == 16'(TIMEOUT - 1);
        pop = state_q == WR_BUS && (Ready || abort);
        rd_done = state_q == RD_BUS && Ready;
        // a write abort holds off new requests so its error never meets an ack
        take = cpu_req && !ack_q && !err_q && state_q != RD_BUS && !(abort && state_q == WR_BUS);
        push = take && cpu_we && !mis && (!full || pop);
        ld_go = take && !cpu_we && !mis && state_q == IDLE && cnt_q == '0;
        state_d = state_q;
        if (state_q == IDLE) state_d = cnt_q != '0 ? WR_BUS : ld_go ? RD_BUS : IDLE;
        else if (state_q == GAP) state_d = IDLE;
        else if (Ready || abort) state_d = GAP;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            tmo_q <= '0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            code_q <= 2'b00;
            rdata_q <= '0;
            a_q <= '0;
            be_q <= '0;
            wd_q <= '0;
            req_q <= 1'b0;
            rw_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (push) begin
                mem_q[wr_q] <= {cpu_addr[AW-1:OW], be_w, wd_w};
                wr_q <= wr_q == PW'(WBUF_DEPTH - 1) ? '0 : wr_q + PW'(1);
            end
            if (pop) rd_q <= rd_q == PW'(WBUF_DEPTH - 1) ? '0 : rd_q + PW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
            req_q <= state_d == WR_BUS || state_d == RD_BUS;
            tmo_q <= state_q == IDLE ? '0 : tmo_q + 16'(req_q && !Ready);
            if (state_q == IDLE && state_d == WR_BUS) {a_q, be_q, wd_q, rw_q} <= {mem_q[rd_q], 1'b0};
            if (state_q == IDLE && state_d == RD_BUS) begin
                a_q <= cpu_addr[AW-1:OW];
                be_q <= be_w;
                rw_q <= 1'b1;
            end
            ack_q <= push || rd_done;
            err_q <= (take && mis) || abort;
            if (abort) code_q <= 2'b10;
            else if (take && mis) code_q <= 2'b01;
            if (rd_done) rdata_q <= (sh & keep) | ({DW{sext}} & ~keep);
        end
    end

    assign cpu_ack = ack_q;
    assign cpu_err = err_q;
    assign cpu_err_code = code_q;
    assign cpu_rdata = rdata_q;
    assign A = a_q;
    assign BE = be_q;
    assign WData = wd_q;
    assign Req = req_q;
    assign RW = rw_q;
    assign wbuf_empty = cnt_q == '0 && state_q != WR_BUS;
endmodule

// File: tb/tb_coco_mem_bus_unit.sv
// tb_coco_mem_bus_unit: directed scoreboard bench for the 32-bit (TIMEOUT=4) and 64-bit configurations.
module tb_coco_mem_bus_unit;
    logic        Clk, Reset;
    logic        cpu_req, cpu_we, cpu_signed;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, WData, RData;
    logic        cpu_ack, cpu_err, Req, RW, Ready, wbuf_empty;
    logic [1:0]  cpu_err_code;
    logic [29:0] A;
    logic [3:0]  BE;

    logic        c64_req, c64_we, c64_signed, ack64, err64, Req64, RW64, wbe64;
    logic [1:0]  c64_size, code64;
    logic [31:0] c64_addr;
    logic [63:0] c64_wdata, rdata64, WData64;
    logic [28:0] A64;
    logic [7:0]  BE64;

    coco_mem_bus_unit #(.DW(32), .AW(32), .WBUF_DEPTH(2), .TIMEOUT(4)) u32 (
        .Clk(Clk), .Reset(Reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
        .cpu_signed(cpu_signed), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .cpu_err_code(cpu_err_code), .A(A), .BE(BE),
        .WData(WData), .RData(RData), .Req(Req), .RW(RW), .Ready(Ready), .wbuf_empty(wbuf_empty));

    coco_mem_bus_unit #(.DW(64), .AW(32), .WBUF_DEPTH(2), .TIMEOUT(255)) u64 (
        .Clk(Clk), .Reset(Reset), .cpu_req(c64_req), .cpu_we(c64_we), .cpu_size(c64_size),
        .cpu_signed(c64_signed), .cpu_addr(c64_addr), .cpu_wdata(c64_wdata), .cpu_ack(ack64),
        .cpu_rdata(rdata64), .cpu_err(err64), .cpu_err_code(code64), .A(A64), .BE(BE64),
        .WData(WData64), .RData(64'h8000_0000_0000_0000), .Req(Req64), .RW(RW64), .Ready(1'b1),
        .wbuf_empty(wbe64));

    typedef struct packed {logic [29:0] a; logic [3:0] be; logic [31:0] wd; logic rw;} bus_t;
    typedef struct packed {logic err; logic [1:0] code; logic [31:0] rd; logic [31:0] lat;} exp_t;
    bus_t bus_q[$];
    exp_t exp_q[$];

    int n_cmp = 0, n_bad = 0, n_ack = 0, n_err = 0, req_rises = 0, rcyc = 0, last_len = 0;
    int rdy_lat = 1, r0, e0, n;
    logic rdy_never = 1'b0;
    logic [31:0] rd_val = '0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_exp(input logic [29:0] a, input logic [3:0] be, input logic [31:0] wd, input logic rw);
        bus_t e;
        e.a = a; e.be = be; e.wd = wd; e.rw = rw;
        bus_q.push_back(e);
    endtask

    task automatic access(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd, input logic ex_err,
                          input logic [1:0] ex_code, input logic [31:0] ex_rd, input int ex_lat);
        exp_t x;
        int k;
        x.err = ex_err; x.code = ex_code; x.rd = ex_rd; x.lat = ex_lat;
        exp_q.push_back(x);
        @(negedge Clk);
        cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_signed = sg; cpu_addr = addr; cpu_wdata = wd;
        k = 0;
        do begin
            @(negedge Clk);
            k++;
        end while (!cpu_ack && !cpu_err && k < 100);
        cpu_req = 1'b0;
        x = exp_q.pop_front();
        chk({tag, "_done"}, 64'(cpu_ack || cpu_err), 1);
        chk({tag, "_err"}, cpu_err, x.err);
        chk({tag, "_ack"}, cpu_ack, !x.err);
        if (x.err) chk({tag, "_code"}, cpu_err_code, x.code);
        else if (!we) chk({tag, "_rdata"}, cpu_rdata, x.rd);
        if (x.lat > 0) chk({tag, "_lat"}, k, x.lat);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (!(wbuf_empty && !Req && bus_q.size() == 0) && k < 60) begin
            @(negedge Clk);
            k++;
        end
        @(negedge Clk);
        chk({tag, "_idle"}, 64'(wbuf_empty && !Req), 1);
        chk({tag, "_bus_done"}, bus_q.size(), 0);
    endtask

    // bus slave: Ready after rdy_lat Req cycles; checks each transaction against bus_q
    initial begin
        bus_t e;
        Ready = 1'b0;
        RData = '0;
        forever begin
            @(negedge Clk);
            if (cpu_ack) n_ack++;
            if (cpu_err) n_err++;
            if (Req) begin
                if (rcyc == 0) begin
                    req_rises++;
                    chk("bus_expected", 64'(bus_q.size() != 0), 1);
                    if (bus_q.size() != 0) begin
                        e = bus_q.pop_front();
                        chk("bus_A", A, e.a);
                        chk("bus_BE", BE, e.be);
                        chk("bus_RW", RW, e.rw);
                        if (!e.rw) chk("bus_WData", WData, e.wd);
                        else chk("rd_wbuf_empty", wbuf_empty, 1);
                    end
                end
                rcyc++;
                Ready = !rdy_never && rcyc >= rdy_lat;
            end else begin
                if (rcyc != 0) last_len = rcyc;
                rcyc = 0;
                Ready = 1'b0;
            end
            RData = rd_val;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_size = 0; cpu_signed = 0; cpu_addr = 0; cpu_wdata = 0;
        c64_req = 0; c64_we = 0; c64_size = 0; c64_signed = 0; c64_addr = 0; c64_wdata = 0;
        repeat (3) @(negedge Clk);
        chk("rst_ack", cpu_ack, 0);
        chk("rst_err", cpu_err, 0);
        chk("rst_code", cpu_err_code, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_A", A, 0);
        chk("rst_BE", BE, 0);
        chk("rst_WData", WData, 0);
        chk("rst_Req", Req, 0);
        chk("rst_RW", RW, 1);
        chk("rst_wbuf_empty", wbuf_empty, 1);
        Reset = 1'b0;

        rdy_lat = 2;
        bus_exp(30'h40, 4'b1000, 32'hABABABAB, 1'b0);
        access("sb", 1, 2'd0, 0, 32'h103, 32'h000000AB, 0, 2'b00, 0, 1);
        chk("sb_wbuf_busy", wbuf_empty, 0);
        wait_idle("sb");
        chk("sb_req_len", last_len, 2);

        rdy_lat = 1;
        rd_val = 32'h8001_1234;
        bus_exp(30'h80, 4'b1100, 0, 1'b1);
        access("lh", 0, 2'd1, 1, 32'h202, 0, 0, 2'b00, 32'hFFFF8001, 2);
        bus_exp(30'h80, 4'b1100, 0, 1'b1);
        access("lhu", 0, 2'd1, 0, 32'h202, 0, 0, 2'b00, 32'h00008001, 2);
        rd_val = 32'h1234_F678;
        bus_exp(30'h80, 4'b0010, 0, 1'b1);
        access("lb", 0, 2'd0, 1, 32'h201, 0, 0, 2'b00, 32'hFFFFFFF6, 2);

        rdy_lat = 4;
        bus_exp(30'h4, 4'hF, 32'h11111111, 1'b0);
        bus_exp(30'h5, 4'hF, 32'h22222222, 1'b0);
        bus_exp(30'h6, 4'hF, 32'h33333333, 1'b0);
        bus_exp(30'h8, 4'hF, 0, 1'b1);
        access("sw1", 1, 2'd2, 0, 32'h10, 32'h11111111, 0, 2'b00, 0, 1);
        access("sw2", 1, 2'd2, 0, 32'h14, 32'h22222222, 0, 2'b00, 0, 1);
        access("sw3_stall", 1, 2'd2, 0, 32'h18, 32'h33333333, 0, 2'b00, 0, 2);
        rdy_lat = 2;
        rd_val = 32'h1234_5678;
        access("lw_after", 0, 2'd2, 0, 32'h20, 0, 0, 2'b00, 32'h12345678, 0);
        wait_idle("lw_after");

        r0 = req_rises;
        access("lw_mis", 0, 2'd2, 0, 32'h6, 0, 1, 2'b01, 0, 1);
        access("sd_on32", 1, 2'd3, 0, 32'h0, 32'h55, 1, 2'b01, 0, 1);
        access("sh_mis", 1, 2'd1, 0, 32'h101, 32'h1234, 1, 2'b01, 0, 1);
        repeat (5) @(negedge Clk);
        chk("mis_no_req", req_rises, r0);
        chk("mis_no_push", wbuf_empty, 1);

        rdy_never = 1'b1;
        bus_exp(30'h10, 4'hF, 0, 1'b1);
        access("lw_tmo", 0, 2'd2, 0, 32'h40, 0, 1, 2'b10, 0, 5);
        repeat (2) @(negedge Clk);
        chk("tmo_req_len", last_len, 4);

        bus_exp(30'h14, 4'hF, 32'hDEADBEEF, 1'b0);
        access("sw_tmo", 1, 2'd2, 0, 32'h50, 32'hDEADBEEF, 0, 2'b00, 0, 1);
        n = 0;
        while (!cpu_err && n < 30) begin
            @(negedge Clk);
            n++;
        end
        chk("wtmo_err", cpu_err, 1);
        chk("wtmo_code", cpu_err_code, 2'b10);
        chk("wtmo_no_ack", cpu_ack, 0);
        wait_idle("wtmo");

        bus_exp(30'h18, 4'hF, 32'hCAFEF00D, 1'b0);
        access("sw_rst", 1, 2'd2, 0, 32'h60, 32'hCAFEF00D, 0, 2'b00, 0, 1);
        n = 0;
        while (!Req && n < 10) begin
            @(negedge Clk);
            n++;
        end
        chk("rst_req_seen", Req, 1);
        Reset = 1'b1;
        @(negedge Clk);
        chk("rstx_Req", Req, 0);
        chk("rstx_RW", RW, 1);
        chk("rstx_wbuf_empty", wbuf_empty, 1);
        chk("rstx_ack", cpu_ack, 0);
        chk("rstx_err", cpu_err, 0);
        Reset = 1'b0;
        rdy_never = 1'b0;
        e0 = n_err;
        repeat (8) @(negedge Clk);
        chk("rstx_no_late_err", n_err, e0);
        chk("rstx_idle_Req", Req, 0);

        @(negedge Clk);
        c64_req = 1; c64_we = 1; c64_size = 2'd3; c64_addr = 32'h8; c64_wdata = 64'h1122334455667788;
        @(negedge Clk);
        chk("sd64_ack", ack64, 1);
        c64_req = 0;
        @(negedge Clk);
        chk("sd64_Req", Req64, 1);
        chk("sd64_A", A64, 1);
        chk("sd64_BE", BE64, 8'hFF);
        chk("sd64_WData", WData64, 64'h1122334455667788);
        chk("sd64_RW", RW64, 0);
        repeat (3) @(negedge Clk);
        c64_req = 1; c64_we = 0; c64_size = 2'd2; c64_signed = 1; c64_addr = 32'hC;
        @(negedge Clk);
        chk("lw64_Req", Req64, 1);
        chk("lw64_BE", BE64, 8'hF0);
        @(negedge Clk);
        chk("lw64_ack", ack64, 1);
        chk("lw64_rdata", rdata64, 64'hFFFFFFFF80000000);
        c64_req = 0;
        repeat (2) @(negedge Clk);
        chk("c64_wbuf_empty", wbe64, 1);
        chk("c64_no_err", err64, 0);

        chk("total_ack", n_ack, 10);
        chk("total_err", n_err, 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
